iob_vexriscv_bus_arbiter: RTL and testbench

Two-master to one-slave arbiter for IOb native buses. It merges the VexRiscv instruction bus (m1) and data bus (m0) onto a single shared memory port (s). Round-robin arbitration holds each grant until the slave accepts the request. Outstanding reads are tracked in an in-order tag FIFO, so each read response returns to the master that issued it. The block sits between the core wrapper and the memory/interconnect when only one memory port is available.

---
 rtl/iob_vexriscv_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_iob_vexriscv_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/iob_vexriscv_bus_arbiter.sv
// Two-master (m0 = dBus, m1 = iBus) to one-slave IOb arbiter with round-robin
// grant, grant lock until acceptance, and an in-order read tag FIFO for responses.
module iob_vexriscv_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                m0_avalid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ready_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_rvalid_o,
  input  logic                m1_avalid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ready_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_rvalid_o,
  output logic                s_avalid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ready_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_rvalid_i,
  output logic                err_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTST) + 1;

  typedef struct packed {
    logic              avalid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  req_t [1:0] m_req;
  req_t       sel;

  logic                 lock, gnt, last, gnt_c;
  logic [MAX_OUTST-1:0] tag_q;
  logic [PTR_W-1:0]     wptr, rptr;
  logic [CNT_W-1:0]     cnt;
  logic                 full, empty, is_rd, stall, acc, push, pop, head;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_req[0] = {m0_avalid_i, m0_addr_i, m0_wdata_i, m0_wstrb_i};
  assign m_req[1] = {m1_avalid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i};

  // A pending (unaccepted) request freezes the grant so request fields stay stable.
  always_comb begin
    gnt_c = gnt;
    if (!lock) begin
      if (m0_avalid_i && m1_avalid_i) gnt_c = ~last;
      else if (m1_avalid_i)           gnt_c = 1'b1;
      else if (m0_avalid_i)           gnt_c = 1'b0;
    end
  end

  assign sel   = m_req[gnt_c];
  assign full  = (cnt == CNT_W'(MAX_OUTST));
  assign empty = (cnt == '0);
  assign is_rd = (sel.wstrb == '0);
  assign stall = full & is_rd;
  assign acc   = s_avalid_o & s_ready_i;
  assign push  = acc & is_rd;
  assign pop   = s_rvalid_i & ~empty;
  assign head  = tag_q[rptr];

  assign s_avalid_o = sel.avalid & ~stall;
  assign s_addr_o   = sel.addr;
  assign s_wdata_o  = sel.wdata;
  assign s_wstrb_o  = sel.wstrb;

  assign m0_ready_o  = acc & ~gnt_c;
  assign m1_ready_o  = acc & gnt_c;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lock  <= 1'b0;
      gnt   <= 1'b0;
      last  <= 1'b1;
      tag_q <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      err_o <= 1'b0;
    end else if (cke_i) begin
      if (acc) begin
        lock <= 1'b0;
        last <= gnt_c;
      end else if (sel.avalid) begin
        lock <= 1'b1;
        gnt  <= gnt_c;
      end
      if (push) begin
        tag_q[wptr] <= gnt_c;
        wptr        <= nxt(wptr);
      end
      if (pop) rptr <= nxt(rptr);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!push && pop) cnt <= cnt - CNT_W'(1);
      if (s_rvalid_i && empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_vexriscv_bus_arbiter.sv
// Directed bench for iob_vexriscv_bus_arbiter; read responses checked via a tag/data scoreboard.
module tb_iob_vexriscv_bus_arbiter;
  logic        clk_i = 1'b0, cke_i, arst_i;
  logic        m0_avalid_i, m1_avalid_i, m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i, m0_rdata_o, m1_rdata_o;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i, s_wstrb_o;
  logic        s_avalid_o, s_ready_i, s_rvalid_i, err_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;

  iob_vexriscv_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .m0_avalid_i(m0_avalid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
    .m0_rvalid_o(m0_rvalid_o),
    .m1_avalid_i(m1_avalid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
    .m1_rvalid_o(m1_rvalid_o),
    .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i),
    .s_rvalid_i(s_rvalid_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;
  typedef struct { logic m; logic [31:0] d; } rd_t;
  rd_t         sbq[$];
  logic [31:0] next_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input logic av, input logic [31:0] a, input logic [3:0] st);
    if (m == 0) begin
      m0_avalid_i = av; m0_addr_i = a; m0_wstrb_i = st; m0_wdata_i = a ^ 32'h5a5a0000;
    end else begin
      m1_avalid_i = av; m1_addr_i = a; m1_wstrb_i = st; m1_wdata_i = a ^ 32'h5a5a0000;
    end
  endtask

  // exp_m: master expected to see ready this cycle (2 = none).
  task automatic tick(input string tag, input int exp_m, input logic exp_sav,
                      input logic [31:0] exp_addr);
    rd_t r;
    if (s_rvalid_i && sbq.size() > 0) s_rdata_i = sbq[0].d;
    #1;
    chk({tag, " s_avalid"}, s_avalid_o, exp_sav);
    if (exp_sav) begin
      chk({tag, " s_addr"}, s_addr_o, exp_addr);
      chk({tag, " s_wdata"}, s_wdata_o, exp_addr ^ 32'h5a5a0000);
    end
    chk({tag, " m0_ready"}, m0_ready_o, exp_m == 0);
    chk({tag, " m1_ready"}, m1_ready_o, exp_m == 1);
    if (s_rvalid_i && sbq.size() > 0) begin
      r = sbq.pop_front();
      chk({tag, " m0_rvalid"}, m0_rvalid_o, !r.m);
      chk({tag, " m1_rvalid"}, m1_rvalid_o, r.m);
      chk({tag, " rdata"}, r.m ? m1_rdata_o : m0_rdata_o, r.d);
    end else begin
      chk({tag, " m0_rvalid idle"}, m0_rvalid_o, 1'b0);
      chk({tag, " m1_rvalid idle"}, m1_rvalid_o, 1'b0);
    end
    if (exp_m == 0 && m0_wstrb_i == 4'h0) sbq.push_back('{1'b0, next_d});
    if (exp_m == 1 && m1_wstrb_i == 4'h0) sbq.push_back('{1'b1, next_d});
    @(posedge clk_i); #2;
  endtask

  initial begin
    cke_i = 1'b1; arst_i = 1'b1;
    drv(0, 1'b0, 32'h0, 4'h0); drv(1, 1'b0, 32'h0, 4'h0);
    s_ready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0; next_d = '0;
    repeat (2) @(posedge clk_i); #2;
    chk("reset err", err_o, 1'b0);
    tick("reset", 2, 1'b0, 32'h0);
    arst_i = 1'b0;

    // single master: 4 reads from m1, responses one cycle later
    s_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv(1, 1'b1, 32'h100 + 4 * k, 4'h0);
      s_rvalid_i = (k > 0);
      next_d = 32'hA0 + k;
      tick("single", 1, 1'b1, 32'h100 + 4 * k);
    end
    drv(1, 1'b0, 32'h0, 4'h0); s_rvalid_i = 1'b1;
    tick("single tail", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b0;

    // contention: both masters writing continuously, grants alternate from m0
    drv(0, 1'b1, 32'h200, 4'hF); drv(1, 1'b1, 32'h300, 4'hF);
    for (int i = 0; i < 6; i++)
      tick("contend", i % 2, 1'b1, (i % 2) ? 32'h300 : 32'h200);
    drv(0, 1'b0, 32'h0, 4'h0); drv(1, 1'b0, 32'h0, 4'h0);

    // lock: m1 held off by the slave while m0 joins
    s_ready_i = 1'b0;
    drv(1, 1'b1, 32'h400, 4'hF);
    tick("lock c0", 2, 1'b1, 32'h400);
    drv(0, 1'b1, 32'h500, 4'hF);
    tick("lock c1", 2, 1'b1, 32'h400);
    tick("lock c2", 2, 1'b1, 32'h400);
    s_ready_i = 1'b1;
    tick("lock acc", 1, 1'b1, 32'h400);
    drv(1, 1'b1, 32'h404, 4'hF);
    tick("lock next m0", 0, 1'b1, 32'h500);
    drv(0, 1'b0, 32'h0, 4'h0);
    tick("lock then m1", 1, 1'b1, 32'h404);
    drv(1, 1'b0, 32'h0, 4'h0);

    // FIFO full: reads stall, writes pass, pop while full
    drv(1, 1'b1, 32'h600, 4'h0); next_d = 32'hB0;
    tick("full rd0", 1, 1'b1, 32'h600);
    drv(1, 1'b1, 32'h604, 4'h0); next_d = 32'hB1;
    tick("full rd1", 1, 1'b1, 32'h604);
    drv(1, 1'b0, 32'h0, 4'h0);
    drv(0, 1'b1, 32'h700, 4'hF); s_rvalid_i = 1'b1;
    tick("full wr+rvalid", 0, 1'b1, 32'h700);
    drv(0, 1'b0, 32'h0, 4'h0); s_rvalid_i = 1'b0;
    drv(1, 1'b1, 32'h608, 4'h0); next_d = 32'hB2;
    tick("full rd2", 1, 1'b1, 32'h608);
    drv(1, 1'b1, 32'h60C, 4'h0); next_d = 32'hB3;
    tick("full stall", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b1;
    tick("full stall+pop", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b0;
    tick("full unstall", 1, 1'b1, 32'h60C);
    drv(1, 1'b0, 32'h0, 4'h0); s_rvalid_i = 1'b1;
    tick("full drain0", 2, 1'b0, 32'h0);
    tick("full drain1", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b0;

    // ordering: m0 read then m1 read, responses in issue order
    drv(0, 1'b1, 32'h800, 4'h0); next_d = 32'h11;
    tick("order m0", 0, 1'b1, 32'h800);
    drv(0, 1'b0, 32'h0, 4'h0);
    drv(1, 1'b1, 32'h900, 4'h0); next_d = 32'h22;
    tick("order m1", 1, 1'b1, 32'h900);
    drv(1, 1'b0, 32'h0, 4'h0); s_rvalid_i = 1'b1;
    tick("order r0", 2, 1'b0, 32'h0);
    tick("order r1", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b0;

    // clock enable low: stray rvalid must not set err
    cke_i = 1'b0; s_rvalid_i = 1'b1;
    tick("cke stray", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b0; cke_i = 1'b1;
    chk("cke err held", err_o, 1'b0);

    // error: stray rvalid sets sticky err from next cycle
    s_rvalid_i = 1'b1;
    tick("err pulse", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b0;
    chk("err set", err_o, 1'b1);
    repeat (3) tick("err idle", 2, 1'b0, 32'h0);
    chk("err sticky", err_o, 1'b1);
    arst_i = 1'b1; #1;
    chk("err cleared", err_o, 1'b0);
    arst_i = 1'b0;

    // reset mid-transaction drops the outstanding tag
    drv(0, 1'b1, 32'hA00, 4'h0); next_d = 32'hCC;
    tick("mid rd", 0, 1'b1, 32'hA00);
    drv(0, 1'b0, 32'h0, 4'h0);
    arst_i = 1'b1; sbq.delete(); #1; arst_i = 1'b0;
    s_rvalid_i = 1'b1;
    tick("post reset resp", 2, 1'b0, 32'h0);
    s_rvalid_i = 1'b0;
    chk("post reset err", err_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
